// File: rtl/banco_registradores_param_pkg.sv
// banco_registradores_param_pkg: shared FSM state encoding for the register file
// Contents: estado_t (ST_IDLE = 1'b0, ST_SWEEP = 1'b1).
package banco_registradores_param_pkg;
   typedef enum logic {ST_IDLE = 1'b0, ST_SWEEP = 1'b1} estado_t;
endpackage

// File: rtl/banco_registradores_param_registrador.sv
// registrador_param: one WIDTH-bit register with load enable and synchronous clear
// Ports: clk, rst_n (async, active low), en (load d), clr (sync clear, wins over en),
//        d (load data), q (stored value).
module registrador_param #(
   parameter int WIDTH = 64
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             clr,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) q <= '0;
      else if (clr) q <= '0;
      else if (en) q <= d;
endmodule

// File: rtl/banco_registradores_param.sv
// banco_registradores_param: register file with handshake write port, async reads,
// optional zero register / write bypass and a one-register-per-cycle bulk clear.
// Ports: clk, rst_n (async, active low); wr_valid/wr_ready/wr_addr/wr_data write port;
//        rd_addr/rd_data packed read ports (port k at k*AW / k*WIDTH);
//        clr_req starts a sweep, clr_busy while sweeping, clr_done pulses once after.
module banco_registradores_param
   import banco_registradores_param_pkg::*;
#(
   parameter int WIDTH    = 64,
   parameter int NREGS    = 32,
   parameter int NREAD    = 2,
   parameter int ZERO_REG = 1,
   parameter int BYPASS   = 1,
   localparam int AW      = $clog2(NREGS)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   wr_valid,
   output logic                   wr_ready,
   input  logic [AW-1:0]          wr_addr,
   input  logic [WIDTH-1:0]       wr_data,
   input  logic [NREAD*AW-1:0]    rd_addr,
   output logic [NREAD*WIDTH-1:0] rd_data,
   input  logic                   clr_req,
   output logic                   clr_busy,
   output logic                   clr_done
);
   localparam logic [AW:0]   NR   = (AW+1)'(NREGS);
   localparam logic [AW-1:0] LAST = AW'(NREGS-1);
   estado_t st, st_nx;
   logic [AW-1:0] cnt;
   logic [WIDTH-1:0] regs [NREGS];
   logic wr_keep;
   // accepted writes that actually land in a register (out of range / r0 are dropped)
   assign wr_keep = wr_valid && wr_ready && ({1'b0, wr_addr} < NR) && !(ZERO_REG != 0 && wr_addr == '0);
   for (genvar i = 0; i < NREGS; i++) begin : g_reg
      if (ZERO_REG != 0 && i == 0) begin : g_zero
         assign regs[i] = '0;
      end else begin : g_ff
         registrador_param #(.WIDTH(WIDTH)) u_reg (
            .clk   (clk),
            .rst_n (rst_n),
            .en    (wr_keep && wr_addr == AW'(i)),
            .clr   (clr_busy && cnt == AW'(i)),
            .d     (wr_data),
            .q     (regs[i])
         );
      end
   end
   for (genvar k = 0; k < NREAD; k++) begin : g_rd
      logic [AW-1:0] ra;
      logic ok, hit;
      assign ra  = rd_addr[k*AW +: AW];
      assign ok  = ({1'b0, ra} < NR) && !(ZERO_REG != 0 && ra == '0);
      assign hit = BYPASS != 0 && wr_keep && wr_addr == ra;
      assign rd_data[k*WIDTH +: WIDTH] = hit ? wr_data : ok ? regs[ra] : '0;
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         st       <= ST_IDLE;
         cnt      <= '0;
         clr_done <= 1'b0;
      end else begin
         st       <= st_nx;
         cnt      <= (st == ST_SWEEP && cnt != LAST) ? cnt + 1'b1 : '0;
         clr_done <= st == ST_SWEEP && cnt == LAST;
      end
   always_comb
      st_nx = (st == ST_IDLE) ? (clr_req ? ST_SWEEP : ST_IDLE) : (cnt == LAST ? ST_IDLE : ST_SWEEP);
   always_comb begin
      wr_ready = st == ST_IDLE;
      clr_busy = st == ST_SWEEP;
   end
endmodule

// File: tb/tb_banco_registradores_param.sv
// tb_banco_registradores_param: random and directed checks of two register file builds
// against array models (default build and a 12x8, 3-port, no-bypass build).
module tb_banco_registradores_param;
   logic clk = 0, rst_n = 0;
   always #5 clk = ~clk;
   logic wv, cr, rdy, busy, done;
   logic [4:0] wa;
   logic [63:0] wd;
   logic [9:0] ra;
   logic [127:0] rd;
   logic wv_s, cr_s, rdy_s, busy_s, done_s;
   logic [3:0] wa_s;
   logic [7:0] wd_s;
   logic [11:0] ra_s;
   logic [23:0] rd_s;
   logic [63:0] mem [32];
   logic [7:0] mem_s [12];
   int n_chk = 0, n_pass = 0;

   banco_registradores_param dut (
      .clk(clk), .rst_n(rst_n), .wr_valid(wv), .wr_ready(rdy), .wr_addr(wa), .wr_data(wd),
      .rd_addr(ra), .rd_data(rd), .clr_req(cr), .clr_busy(busy), .clr_done(done));

   banco_registradores_param #(.WIDTH(8), .NREGS(12), .NREAD(3), .ZERO_REG(1), .BYPASS(0)) dut_s (
      .clk(clk), .rst_n(rst_n), .wr_valid(wv_s), .wr_ready(rdy_s), .wr_addr(wa_s), .wr_data(wd_s),
      .rd_addr(ra_s), .rd_data(rd_s), .clr_req(cr_s), .clr_busy(busy_s), .clr_done(done_s));

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) $display("FAIL %s got %h expected %h", tag, got, exp);
      else n_pass++;
   endtask

   function automatic logic [63:0] exp_m(input logic [4:0] a, input bit acc);
      if (acc && wv && wa == a && a != 0) return wd;
      return a == 0 ? 64'd0 : mem[a];
   endfunction

   function automatic logic [7:0] exp_s(input logic [3:0] a);
      return (a == 0 || a >= 12) ? 8'd0 : mem_s[a];
   endfunction

   task automatic clr_models();
      foreach (mem[i]) mem[i] = '0;
      foreach (mem_s[i]) mem_s[i] = '0;
   endtask

   task automatic commit();
      if (wv && wa != 0) mem[wa] = wd;
      if (wv_s && wa_s != 0 && wa_s < 12) mem_s[wa_s] = wd_s;
   endtask

   task automatic write_m(input logic [4:0] a, input logic [63:0] d);
      @(negedge clk);
      wv = 1; wa = a; wd = d;
      @(posedge clk);
      commit();
      #1 wv = 0;
   endtask

   task automatic write_s(input logic [3:0] a, input logic [7:0] d);
      @(negedge clk);
      wv_s = 1; wa_s = a; wd_s = d;
      @(posedge clk);
      commit();
      #1 wv_s = 0;
   endtask

   task automatic read_all_zero(input string tag);
      for (int a = 0; a < 32; a++) begin
         ra = {5'(a), 5'(a)};
         #1;
         check(tag, rd[63:0], 64'd0);
         check(tag, rd[127:64], 64'd0);
      end
   endtask

   initial begin
      wv = 0; cr = 0; wa = 0; wd = 0; ra = 0;
      wv_s = 0; cr_s = 0; wa_s = 0; wd_s = 0; ra_s = 0;
      clr_models();
      repeat (2) @(negedge clk);
      rst_n = 1;
      check("rst_ready", rdy, 1); check("rst_busy", busy, 0); check("rst_done", done, 0);
      check("rst_ready_s", rdy_s, 1); check("rst_busy_s", busy_s, 0);
      read_all_zero("rst_read");
      for (int a = 0; a < 16; a++) begin
         ra_s = {4'(a), 4'(a), 4'(a)};
         #1;
         for (int k = 0; k < 3; k++) check("rst_read_s", rd_s[k*8 +: 8], 0);
      end
      write_m(5, 64'hDEAD_BEEF_0000_0001);
      @(negedge clk); ra[4:0] = 5; #1;
      check("r5", rd[63:0], 64'hDEAD_BEEF_0000_0001);
      write_m(0, 64'h1234);
      @(negedge clk); ra[4:0] = 0; #1;
      check("r0", rd[63:0], 0);
      @(negedge clk);
      wv = 1; wa = 7; wd = 64'hAAAA; ra[9:5] = 7;
      wv_s = 1; wa_s = 7; wd_s = 8'hAA; ra_s[7:4] = 7;
      #1;
      check("bypass", rd[127:64], 64'hAAAA);
      check("nobypass_pre", rd_s[15:8], 0);
      @(posedge clk); commit();
      #1 wv = 0; wv_s = 0;
      #1;
      check("bypass_post", rd[127:64], 64'hAAAA);
      check("nobypass_post", rd_s[15:8], 8'hAA);
      repeat (300) begin
         @(negedge clk);
         wv = 1'($urandom); wa = 5'($urandom); wd = {$urandom, $urandom}; ra = 10'($urandom);
         wv_s = 1'($urandom); wa_s = 4'($urandom); wd_s = 8'($urandom); ra_s = 12'($urandom);
         #1;
         for (int k = 0; k < 2; k++) check("rand_rd", rd[k*64 +: 64], exp_m(ra[k*5 +: 5], 1));
         for (int k = 0; k < 3; k++) check("rand_rd_s", rd_s[k*8 +: 8], exp_s(ra_s[k*4 +: 4]));
         @(posedge clk); commit();
      end
      #1 wv = 0; wv_s = 0;
      for (int a = 1; a < 32; a++) write_m(5'(a), 64'(a));
      @(negedge clk); cr = 1;
      @(posedge clk); #1 cr = 0;
      for (int c = 0; c < 32; c++) begin
         @(negedge clk);
         wv = 1; wa = 5'($urandom); wd = {$urandom, $urandom}; ra = {5'($urandom), 5'(c)};
         #1;
         check("sw_busy", busy, 1); check("sw_ready", rdy, 0); check("sw_done", done, 0);
         check("sw_rd0", rd[63:0], exp_m(ra[4:0], 0));
         check("sw_rd1", rd[127:64], exp_m(ra[9:5], 0));
         @(posedge clk); mem[c] = '0;
      end
      @(negedge clk); wv = 0; #1;
      check("end_busy", busy, 0); check("end_ready", rdy, 1); check("end_done", done, 1);
      @(negedge clk);
      check("done_pulse", done, 0);
      read_all_zero("after_sweep");
      for (int a = 1; a < 32; a++) write_m(5'(a), {$urandom, $urandom});
      @(negedge clk); cr = 1;
      @(posedge clk); #1 cr = 0;
      repeat (10) @(posedge clk);
      @(negedge clk); rst_n = 0; clr_models();
      #1;
      check("rst_mid_busy", busy, 0); check("rst_mid_ready", rdy, 1);
      read_all_zero("rst_mid_read");
      @(negedge clk); rst_n = 1;
      repeat (3) begin
         @(negedge clk);
         check("rst_mid_nodone", done, 0); check("rst_mid_idle", busy, 0);
      end
      write_m(3, 64'h0123_4567_89AB_CDEF);
      @(negedge clk); ra[4:0] = 3; #1;
      check("r3_after_rst", rd[63:0], 64'h0123_4567_89AB_CDEF);
      write_s(11, 8'h5A);
      @(negedge clk); ra_s = {4'd11, 4'd11, 4'd11}; #1;
      for (int k = 0; k < 3; k++) check("s_r11", rd_s[k*8 +: 8], 8'h5A);
      ra_s = {4'd13, 4'd13, 4'd13}; #1;
      for (int k = 0; k < 3; k++) check("s_r13", rd_s[k*8 +: 8], 0);
      @(negedge clk); cr_s = 1;
      @(posedge clk); #1 cr_s = 0;
      begin
         int n = 0;
         while (busy_s === 1'b1 && n < 100) begin
            n++;
            @(posedge clk); #1;
         end
         check("s_sweep_len", 64'(n), 12);
         check("s_done", done_s, 1);
      end
      foreach (mem_s[i]) mem_s[i] = '0;
      ra_s = {4'd11, 4'd5, 4'd11}; #1;
      for (int k = 0; k < 3; k++) check("s_cleared", rd_s[k*8 +: 8], exp_s(ra_s[k*4 +: 4]));
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
